// File: rtl/keypad_alu_pkg.sv
// Shared types for the keypad calculator: FSM state and operator encodings,
// plus the width helper for the key debounce counter.
package keypad_alu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        SHOW   = 2'd3
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // Bits needed for a counter that must be able to hold the value `cycles`.
    function automatic int dbc_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low pushbutton conditioning: 2-flop synchroniser, stable-level
// debounce counter and a one-cycle press pulse on a debounced high-to-low edge.
import keypad_alu_pkg::*;

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int CW = dbc_width(DEBOUNCE_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // Synchroniser and debounce state; everything resets to the released level
    // so a key held through reset is seen as a fresh press.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
                r_press <= r_level;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/keypad_alu_fsm.sv
// Two-operand switch calculator stepped by debounced KEY[0]; result carries
// the full WIDTH+1 sum. Define SUB_MODE_EN to enable subtract selected by KEY[1].
import keypad_alu_pkg::*;

module keypad_alu_fsm #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             MAX10_CLK1_50,
    input  logic             rst,
    input  logic [WIDTH-1:0] SW,
    input  logic [1:0]       KEY,
    output logic [WIDTH:0]   result,
    output logic             result_valid,
    output logic             neg,
    output logic [1:0]       state_o
);

    logic             w_press;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_result;
    logic             w_neg;
    op_t              w_op;
    logic             w_unused;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   r_result;
    logic             r_neg;
    logic             r_valid;
    op_t              r_op;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key0 (
        .i_clk   (MAX10_CLK1_50),
        .i_rst   (rst),
        .i_key_n (KEY[0]),
        .o_press (w_press)
    );

    assign w_sum = {1'b0, r_a} + {1'b0, SW};

`ifdef SUB_MODE_EN
    logic r_key1_s1;
    logic r_key1_s2;

    // KEY[1] is a level select, so it is only synchronised.
    always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
        if (rst) begin
            r_key1_s1 <= 1'b1;
            r_key1_s2 <= 1'b1;
        end else begin
            r_key1_s1 <= KEY[1];
            r_key1_s2 <= r_key1_s1;
        end
    end

    // Operator and result for the capture edge; B comes straight from SW.
    always_comb begin
        w_op     = r_key1_s2 ? OP_ADD : OP_SUB;
        w_result = w_sum;
        w_neg    = 1'b0;
        if (w_op == OP_SUB) begin
            if (SW > r_a) begin
                w_result = {1'b0, SW - r_a};
                w_neg    = 1'b1;
            end else begin
                w_result = {1'b0, r_a - SW};
                w_neg    = 1'b0;
            end
        end else begin
            w_result = w_sum;
            w_neg    = 1'b0;
        end
    end

    assign w_unused = ^{r_b, r_op};
`else
    assign w_op     = OP_ADD;
    assign w_result = w_sum;
    assign w_neg    = 1'b0;
    assign w_unused = ^{KEY[1], r_b, r_op};
`endif

    // Operand-entry state machine with registered result and status outputs.
    always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_valid  <= 1'b0;
            r_op     <= OP_ADD;
        end else begin
            case (r_state)
                IDLE: begin
                    r_a      <= '0;
                    r_b      <= '0;
                    r_result <= '0;
                    r_neg    <= 1'b0;
                    r_valid  <= 1'b0;
                    r_op     <= OP_ADD;
                    if (w_press) begin
                        r_state <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    if (w_press) begin
                        r_a     <= SW;
                        r_state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (w_press) begin
                        r_b      <= SW;
                        r_op     <= w_op;
                        r_result <= w_result;
                        r_neg    <= w_neg;
                        r_valid  <= 1'b1;
                        r_state  <= SHOW;
                    end
                end
                SHOW: begin
                    if (w_press) begin
                        r_result <= '0;
                        r_neg    <= 1'b0;
                        r_valid  <= 1'b0;
                        r_op     <= OP_ADD;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign result       = r_result;
    assign result_valid = r_valid;
    assign neg          = r_neg;
    assign state_o      = r_state;

endmodule

// File: tb/tb_keypad_alu_fsm.sv
// Scoreboard bench for keypad_alu_fsm: a 4-bit and an 8-bit instance stepped
// in lockstep by the same keys; expected results are queued at the B capture.
module tb_keypad_alu_fsm;

`ifdef SUB_MODE_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] sw4;
    logic [7:0] sw8;
    logic [1:0] key;
    logic [4:0] result4;
    logic [8:0] result8;
    logic       valid4, valid8, neg4, neg8;
    logic [1:0] st4, st8;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0]  m_state;
    logic [3:0]  m_a4;
    logic [7:0]  m_a8;
    logic [16:0] q4[$];
    logic [16:0] q8[$];

    keypad_alu_fsm #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) u_dut4 (
        .MAX10_CLK1_50 (clk), .rst (rst), .SW (sw4), .KEY (key),
        .result (result4), .result_valid (valid4), .neg (neg4), .state_o (st4)
    );

    keypad_alu_fsm #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) u_dut8 (
        .MAX10_CLK1_50 (clk), .rst (rst), .SW (sw8), .KEY (key),
        .result (result8), .result_valid (valid8), .neg (neg8), .state_o (st8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference arithmetic: {neg, magnitude}.
    function automatic logic [16:0] model(input int a, input int b, input bit sub);
        if (!sub)       return {1'b0, 16'(a + b)};
        else if (a >= b) return {1'b0, 16'(a - b)};
        else            return {1'b1, 16'(b - a)};
    endfunction

    // One debounced step; captures, scoreboard pop on SHOW, clear check on IDLE.
    task automatic step(input logic [3:0] v4, input logic [7:0] v8);
        logic [1:0]  s0, exp_st;
        logic [16:0] e4, e8;
        int n;
        s0 = st4;
        exp_st = m_state + 2'd1;
        sw4 = v4; sw8 = v8; key[0] = 1'b0; n = 0;
        while (st4 === s0 && n < 30) begin @(negedge clk); n++; end
        vectors++;
        if (st4 !== exp_st) begin
            miscompares++;
            $display("FAIL step_state4: got %0d, expected %0d (after %0d cycles)", st4, exp_st, n);
        end
        vectors++;
        if (st8 !== exp_st) begin
            miscompares++;
            $display("FAIL step_state8: got %0d, expected %0d", st8, exp_st);
        end
        if (m_state == 2'd1) begin
            m_a4 = v4; m_a8 = v8;
        end else if (m_state == 2'd2) begin
            q4.push_back(model(int'(m_a4), int'(v4), SUB_EN && (key[1] == 1'b0)));
            q8.push_back(model(int'(m_a8), int'(v8), SUB_EN && (key[1] == 1'b0)));
        end
        m_state = exp_st;
        sw4 = 4'($urandom); sw8 = 8'($urandom);
        repeat (2) @(negedge clk);
        if (m_state == 2'd3) begin
            vectors++;
            if (q4.size() == 0 || q8.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty: SHOW reached with no expected result queued");
            end else begin
                e4 = q4.pop_front(); e8 = q8.pop_front();
                if (result4 !== e4[4:0] || neg4 !== e4[16] || valid4 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL show4: result=%0d neg=%b valid=%b, expected result=%0d neg=%b valid=1",
                             result4, neg4, valid4, e4[4:0], e4[16]);
                end
                vectors++;
                if (result8 !== e8[8:0] || neg8 !== e8[16] || valid8 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL show8: result=%0d neg=%b valid=%b, expected result=%0d neg=%b valid=1",
                             result8, neg8, valid8, e8[8:0], e8[16]);
                end
            end
        end else if (m_state == 2'd0) begin
            vectors++;
            if (result4 !== 5'd0 || neg4 !== 1'b0 || valid4 !== 1'b0 || result8 !== 9'd0) begin
                miscompares++;
                $display("FAIL idle_clear: result4=%0d neg4=%b valid4=%b result8=%0d, expected all 0",
                         result4, neg4, valid4, result8);
            end
        end
        key[0] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic goto_idle();
        while (m_state != 2'd0) step(4'($urandom), 8'($urandom));
    endtask

    task automatic full_op(input logic [3:0] a4, input logic [3:0] b4,
                           input logic [7:0] a8, input logic [7:0] b8);
        goto_idle();
        step(4'd0, 8'd0);
        step(a4, a8);
        step(b4, b8);
    endtask

    task automatic test_reset();
        rst = 1'b1; key = 2'b11; sw4 = 4'd0; sw8 = 8'd0;
        m_state = 2'd0; m_a4 = 4'd0; m_a8 = 8'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if (st4 !== 2'd0 || result4 !== 5'd0 || valid4 !== 1'b0 || neg4 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset4: st=%0d result=%0d valid=%b neg=%b, expected 0", st4, result4, valid4, neg4);
        end
        vectors++;
        if (st8 !== 2'd0 || result8 !== 9'd0 || valid8 !== 1'b0 || neg8 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset8: st=%0d result=%0d valid=%b neg=%b, expected 0", st8, result8, valid8, neg8);
        end
        rst = 1'b0;
        repeat (12) @(negedge clk);
        vectors++;
        if (st4 !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_no_press: st=%0d, expected 0", st4);
        end
    endtask

    task automatic test_add();
        key[1] = 1'b1;
        full_op(4'd9, 4'd7, 8'd9, 8'd7);
        vectors++;
        if (result4 !== 5'b10000 || st4 !== 2'd3) begin
            miscompares++;
            $display("FAIL add_9_7: result=%0d st=%0d, expected 16 st=3", result4, st4);
        end
        goto_idle();
    endtask

    task automatic test_add_patterns();
        logic [3:0] ta[4] = '{4'd15, 4'd0, 4'd3, 4'd8};
        logic [3:0] tb[4] = '{4'd15, 4'd0, 4'd4, 4'd8};
        key[1] = 1'b1;
        for (int i = 0; i < 4; i++) full_op(ta[i], tb[i], {4'd0, ta[i]}, {4'd1, tb[i]});
        goto_idle();
    endtask

    task automatic test_subtract();
        logic [3:0] ta[3] = '{4'd3, 4'd10, 4'd6};
        logic [3:0] tb[3] = '{4'd10, 4'd3, 4'd6};
        key[1] = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) full_op(ta[i], tb[i], {4'd0, ta[i]}, {4'd0, tb[i]});
        goto_idle();
        vectors++;
        if (neg4 !== 1'b0 || neg8 !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_idle_neg: neg4=%b neg8=%b, expected 0", neg4, neg8);
        end
        key[1] = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_width();
        key[1] = 1'b1;
        full_op(4'd15, 4'd1, 8'd255, 8'd255);
        vectors++;
        if (result8 !== 9'h1FE) begin
            miscompares++;
            $display("FAIL width8_255_255: result=%0d, expected 510", result8);
        end
        goto_idle();
    endtask

    task automatic test_bounce();
        int first, changes;
        logic [1:0] prev;
        goto_idle();
        key[0] = 1'b0; repeat (3) @(negedge clk);
        key[0] = 1'b1; repeat (2) @(negedge clk);
        key[0] = 1'b0; first = -1; changes = 0; prev = st4;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (st4 !== prev) begin changes++; if (first < 0) first = j; prev = st4; end
        end
        key[0] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (st4 !== prev) begin changes++; prev = st4; end
        end
        vectors++;
        if (changes != 1 || first != 8 || st4 !== 2'd1) begin
            miscompares++;
            $display("FAIL bounce: changes=%0d first=%0d st=%0d, expected 1 change at cycle 8 to st=1",
                     changes, first, st4);
        end
        m_state = 2'd1;
        goto_idle();
    endtask

    task automatic test_held();
        int changes;
        logic [1:0] prev;
        goto_idle();
        sw4 = 4'd0; sw8 = 8'd0;
        key[0] = 1'b0; changes = 0; prev = st4;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (st4 !== prev) begin changes++; prev = st4; end
        end
        vectors++;
        if (changes != 1 || st4 !== 2'd1) begin
            miscompares++;
            $display("FAIL held_one_press: changes=%0d st=%0d, expected 1 change to st=1", changes, st4);
        end
        m_state = 2'd1;
        key[0] = 1'b1; repeat (3) @(negedge clk);
        key[0] = 1'b0; changes = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (st4 !== prev) begin changes++; prev = st4; end
        end
        vectors++;
        if (changes != 0) begin
            miscompares++;
            $display("FAIL short_release: changes=%0d, expected 0", changes);
        end
        key[0] = 1'b1; repeat (10) @(negedge clk);
        key[0] = 1'b0; changes = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (st4 !== prev) begin changes++; prev = st4; end
        end
        vectors++;
        if (changes != 1 || st4 !== 2'd2) begin
            miscompares++;
            $display("FAIL second_press: changes=%0d st=%0d, expected 1 change to st=2", changes, st4);
        end
        m_a4 = 4'd0; m_a8 = 8'd0; m_state = 2'd2;
        key[0] = 1'b1; repeat (10) @(negedge clk);
        step(4'd6, 8'd200);
        goto_idle();
    endtask

    task automatic test_reset_mid();
        goto_idle();
        key[1] = 1'b1;
        step(4'd0, 8'd0);
        step(4'd5, 8'd5);
        rst = 1'b1;
        #1;
        vectors++;
        if (st4 !== 2'd0 || result4 !== 5'd0 || st8 !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_load_b: st4=%0d result4=%0d st8=%0d, expected 0", st4, result4, st8);
        end
        @(negedge clk); rst = 1'b0; m_state = 2'd0;
        repeat (3) @(negedge clk);
        full_op(4'd2, 4'd2, 8'd2, 8'd2);
        vectors++;
        if (result4 !== 5'd4) begin
            miscompares++;
            $display("FAIL after_reset_2_2: result=%0d, expected 4", result4);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (st4 !== 2'd0 || result4 !== 5'd0 || valid4 !== 1'b0 || result8 !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_show: st=%0d result=%0d valid=%b result8=%0d, expected 0",
                     st4, result4, valid4, result8);
        end
        @(negedge clk); rst = 1'b0; m_state = 2'd0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_key_through_reset();
        int changes;
        logic [1:0] prev;
        goto_idle();
        key[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; m_state = 2'd0; changes = 0; prev = st4;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (st4 !== prev) begin changes++; prev = st4; end
        end
        vectors++;
        if (changes != 1 || st4 !== 2'd1) begin
            miscompares++;
            $display("FAIL key_through_reset: changes=%0d st=%0d, expected 1 change to st=1", changes, st4);
        end
        m_state = 2'd1;
        key[0] = 1'b1; repeat (10) @(negedge clk);
        goto_idle();
    endtask

    initial begin
        test_reset();
        test_add();
        test_add_patterns();
        test_subtract();
        test_width();
        test_bounce();
        test_held();
        test_reset_mid();
        test_key_through_reset();
        vectors++;
        if (q4.size() != 0 || q8.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d/%0d results never shown, expected 0", q4.size(), q8.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
